// File: rtl/cache_way_ctrl.sv
// cache_way_ctrl: 4-way set-associative tag/state controller with writeback and refill sequencing.
module cache_way_ctrl #(
  parameter int SETS = 16,
  parameter int WAYS = 4,
  parameter int OFFSET_W = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        req_valid,
  input  logic                        req_we,
  input  logic [31:0]                 req_addr,
  output logic                        req_ready,
  output logic [$clog2(WAYS)-1:0]     hit_way,
  input  logic [$clog2(WAYS)-1:0]     lru_way,
  output logic                        lru_we,
  output logic [$clog2(WAYS)-1:0]     lru_in,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_ack,
  output logic                        fill_we,
  output logic [$clog2(SETS)-1:0]     fill_set,
  output logic [$clog2(WAYS)-1:0]     fill_way
);
  localparam int IW = $clog2(SETS);
  localparam int WW = $clog2(WAYS);
  localparam int TW = 32 - IW - OFFSET_W;
  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tags [SETS][WAYS];
  logic [WAYS-1:0] valid [SETS];
  logic [WAYS-1:0] dirty [SETS];
  logic [TW-1:0] l_tag;
  logic [IW-1:0] l_idx;
  logic [WW-1:0] v_way;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic hit, inv, miss;
  logic [WW-1:0] hw, inv_way, victim;
  assign idx = req_addr[OFFSET_W +: IW];
  assign tag = req_addr[31 -: TW];
  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit = 1'b0;
    hw = '0;
    inv = 1'b0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (valid[idx][i] && tags[idx][i] == tag) begin
        hit = 1'b1;
        hw = WW'(i);
      end
      if (!valid[idx][i]) begin
        inv = 1'b1;
        inv_way = WW'(i);
      end
    end
  end
  assign victim = inv ? inv_way : lru_way;
  assign miss = state == IDLE && req_valid && !hit;
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = miss ? (valid[idx][victim] && dirty[idx][victim] ? WB : REFILL) : IDLE;
    else if (mem_ack)
      state_nx = state == WB ? REFILL : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge CLK) begin
    if (!RST && miss) begin
      l_tag <= tag;
      l_idx <= idx;
      v_way <= victim;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else if (req_ready && req_we) begin
      dirty[idx][hw] <= 1'b1;
    end else if (fill_we) begin
      valid[l_idx][v_way] <= 1'b1;
      dirty[l_idx][v_way] <= 1'b0;
    end
  end
  // Tags are deliberately not reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill_we) tags[l_idx][v_way] <= l_tag;
  end
  assign req_ready = state == IDLE && req_valid && hit;
  assign hit_way = req_ready ? hw : '0;
  assign lru_we = req_ready;
  assign lru_in = hit_way;
  assign mem_wr = state == WB;
  assign mem_rd = state == REFILL;
  assign fill_we = mem_rd && mem_ack && !RST;
  assign mem_addr = mem_wr ? {tags[l_idx][v_way], l_idx, {OFFSET_W{1'b0}}} :
                    mem_rd ? {l_tag, l_idx, {OFFSET_W{1'b0}}} : 32'h0;
  assign fill_set = state == IDLE ? '0 : l_idx;
  assign fill_way = state == IDLE ? '0 : v_way;
endmodule

// File: tb/tb_cache_way_ctrl.sv
// tb_cache_way_ctrl: directed scenarios plus random accesses checked against a per-line cache model.
module tb_cache_way_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, req_valid = 1'b0, req_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0] lru_way = 2'd0;
  logic req_ready, lru_we, mem_rd, mem_wr, fill_we;
  logic [1:0] hit_way, lru_in, fill_way;
  logic [31:0] mem_addr;
  logic [3:0] fill_set;
  logic [23:0] m_tag [16][4];
  bit m_val [16][4];
  bit m_dty [16][4];
  int n_chk = 0, n_pass = 0;

  cache_way_ctrl dut (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_ready(req_ready), .hit_way(hit_way), .lru_way(lru_way), .lru_we(lru_we),
    .lru_in(lru_in), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .fill_we(fill_we), .fill_set(fill_set), .fill_way(fill_way)
  );

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", t, got, exp);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 4; w++) begin
        m_val[s][w] = 1'b0;
        m_dty[s][w] = 1'b0;
      end
  endtask

  task automatic idle_check(input string t);
    req_valid = 1'b0;
    req_we = 1'($urandom);
    req_addr = $urandom;
    mem_ack = 1'($urandom);
    @(negedge clk);
    chk(t, 32'({req_ready, lru_we, mem_rd, mem_wr, fill_we, hit_way, lru_in, fill_set, fill_way}), 32'h0);
    chk({t, "_addr"}, mem_addr, 32'h0);
    next_cycle();
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = 1'b0;
    mem_ack = 1'b1;
    next_cycle();
    rst = 1'b0;
    model_clear();
    idle_check("reset_out");
  endtask

  task automatic access(input logic [31:0] a, input bit we, input logic [1:0] lru,
                        input int dwb, input int drf, input bit abort);
    logic [3:0] idx;
    logic [23:0] tg;
    bit found, wb;
    logic [1:0] hw, v;
    idx = a[7:4];
    tg = a[31:8];
    found = 1'b0;
    hw = 2'd0;
    for (int w = 3; w >= 0; w--)
      if (m_val[idx][w] && m_tag[idx][w] == tg) begin
        found = 1'b1;
        hw = 2'(w);
      end
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    lru_way = lru;
    mem_ack = 1'($urandom);
    @(negedge clk);
    if (found) begin
      chk("hit_ready", 32'(req_ready), 32'd1);
      chk("hit_way", 32'(hit_way), 32'(hw));
      chk("hit_lru", 32'({lru_we, lru_in}), 32'({1'b1, hw}));
      chk("hit_nomem", 32'({mem_rd, mem_wr, fill_we}), 32'h0);
      next_cycle();
      if (we) m_dty[idx][hw] = 1'b1;
    end else begin
      v = lru;
      for (int w = 3; w >= 0; w--) if (!m_val[idx][w]) v = 2'(w);
      wb = m_val[idx][v] && m_dty[idx][v];
      chk("miss_quiet", 32'({req_ready, lru_we, mem_rd, mem_wr, fill_we}), 32'h0);
      next_cycle();
      req_addr = $urandom;
      req_we = 1'($urandom);
      if (wb)
        for (int c = 0; c <= dwb; c++) begin
          mem_ack = c == dwb;
          @(negedge clk);
          chk("wb_rdwr", 32'({mem_rd, mem_wr}), 32'h1);
          chk("wb_addr", mem_addr, {m_tag[idx][v], idx, 4'h0});
          chk("wb_loc", 32'({fill_set, fill_way}), 32'({idx, v}));
          chk("wb_quiet", 32'({req_ready, lru_we, fill_we}), 32'h0);
          next_cycle();
        end
      for (int c = 0; c <= drf; c++) begin
        mem_ack = c == drf;
        if (abort && c == drf) rst = 1'b1;
        @(negedge clk);
        chk("rf_rdwr", 32'({mem_rd, mem_wr}), 32'h2);
        chk("rf_addr", mem_addr, {tg, idx, 4'h0});
        chk("rf_loc", 32'({fill_set, fill_way}), 32'({idx, v}));
        chk("rf_fill", 32'(fill_we), 32'(c == drf && !abort));
        chk("rf_quiet", 32'({req_ready, lru_we}), 32'h0);
        next_cycle();
      end
      if (abort) begin
        rst = 1'b0;
        model_clear();
        idle_check("abort_out");
      end else begin
        m_tag[idx][v] = tg;
        m_val[idx][v] = 1'b1;
        m_dty[idx][v] = 1'b0;
        req_addr = a;
        req_we = we;
        mem_ack = 1'($urandom);
        @(negedge clk);
        chk("rl_ready", 32'(req_ready), 32'd1);
        chk("rl_way", 32'(hit_way), 32'(v));
        chk("rl_lru", 32'({lru_we, lru_in}), 32'({1'b1, v}));
        chk("rl_nomem", 32'({mem_rd, mem_wr, fill_we}), 32'h0);
        next_cycle();
        if (we) m_dty[idx][v] = 1'b1;
      end
    end
    req_valid = 1'b0;
  endtask

  initial begin
    model_clear();
    do_reset();
    access(32'h0000_1230, 1'b0, 2'd2, 0, 1, 1'b0);
    for (int w = 1; w < 4; w++) access(32'h0000_1230 + 32'(w) * 32'h100, 1'b0, 2'd0, 0, 0, 1'b0);
    access(32'h0000_1430, 1'b1, 2'd0, 0, 0, 1'b0);
    access(32'h0000_1334, 1'b1, 2'd0, 0, 0, 1'b0);
    access(32'h0000_9930, 1'b0, 2'd1, 2, 1, 1'b0);
    access(32'h0000_9930, 1'b0, 2'd0, 0, 0, 1'b0);
    do_reset();
    for (int w = 0; w < 4; w++) access(32'h0000_5050 + 32'(w) * 32'h100, 1'b0, 2'd0, 0, 0, 1'b0);
    access(32'h0000_AA50, 1'b0, 2'd3, 0, 2, 1'b0);
    access(32'h0000_1230, 1'b0, 2'd0, 0, 3, 1'b1);
    access(32'h0000_1230, 1'b0, 2'd0, 0, 0, 1'b0);
    access(32'h0000_2230, 1'b1, 2'd0, 0, 0, 1'b0);
    access(32'h0000_2230, 1'b1, 2'd0, 0, 0, 1'b0);
    for (int w = 0; w < 3; w++) access(32'h0000_3230 + 32'(w) * 32'h100, 1'b0, 2'd0, 0, 0, 1'b0);
    access(32'h0000_7730, 1'b0, 2'd1, 0, 0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      access(($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15),
             1'($urandom), 2'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) idle_check("gap_out");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
